mut_ram_bwe: RTL and testbench

Parametrised single-port synchronous memory-under-test model for PMBIST bring-up; successor to the fixed-latency single-port RAM.
- Sits behind `mem_interface` in the virtual netlist and consumes its full `tomem_*` control set (cs, we, re, oe, odd_bwe, even_bwe).
- Adds configurable read latency, odd/even bit write enables, a valid strobe, and optional stuck-at fault injection so MBIST algorithms can be proven to detect failures.

---
 rtl/pmbist_pkg.sv | 18 +
 rtl/mut_ram_bwe_rd_pipe.sv | 55 +++++
 rtl/mut_ram_bwe.sv | 146 ++++++++++++++
 tb/tb_mut_ram_bwe.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmbist_pkg.sv
// Shared types and limits for the PMBIST memory-under-test models.
package pmbist;

   localparam int MUT_MAX_READ_LATENCY = 4;

   // Fault slot fields are held at fixed maximum widths so the type does not
   // depend on any one memory's geometry; users zero-extend before comparing.
   localparam int MUT_FAULT_ADDR_W = 32;
   localparam int MUT_FAULT_BIT_W  = 16;

   typedef struct packed {
      logic                        en;
      logic [MUT_FAULT_ADDR_W-1:0] addr;
      logic [MUT_FAULT_BIT_W-1:0]  bitpos;
      logic                        val;
   } mut_fault_t;

endpackage

// File: rtl/mut_ram_bwe_rd_pipe.sv
// Read pipeline: valid/data shift register of depth READ_LATENCY.
// Valid advances every cycle; a stage's data only moves when a valid read
// reaches it, so the last stage holds the most recent result.
module mut_rd_pipe
   import pmbist::*;
#(
   parameter int DATA_WIDTH   = 7,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  valid_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] data_o
);

   localparam int DEPTH = (READ_LATENCY < 1) ? 1 :
                          (READ_LATENCY > MUT_MAX_READ_LATENCY) ? MUT_MAX_READ_LATENCY :
                          READ_LATENCY;

   logic                  valid_q [DEPTH];
   logic [DATA_WIDTH-1:0] data_q  [DEPTH];
   logic                  valid_d [DEPTH];
   logic [DATA_WIDTH-1:0] data_d  [DEPTH];

   // Next state: shift valid, move data only alongside a valid read
   always_comb begin
      valid_d[0] = valid_i;
      data_d[0]  = valid_i ? data_i : data_q[0];
      for (int unsigned i = 1; i < DEPTH; i++) begin
         valid_d[i] = valid_q[i-1];
         data_d[i]  = valid_q[i-1] ? data_q[i-1] : data_q[i];
      end
   end

   // Stage registers with synchronous clear
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            valid_q[i] <= 1'b0;
            data_q[i]  <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            valid_q[i] <= valid_d[i];
            data_q[i]  <= data_d[i];
         end
      end
   end

   assign valid_o = valid_q[DEPTH-1];
   assign data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/mut_ram_bwe.sv
// Single-port memory-under-test with odd/even bit write enables, configurable
// read latency and a valid strobe. Define MUT_FAULT_INJECT_EN to build the
// stuck-at fault slots that mask read data; otherwise fault_* are ignored.
module mut_ram_bwe
   import pmbist::*;
#(
   parameter  int DATA_WIDTH   = 7,
   parameter  int ADDR_WIDTH   = 4,
   parameter  int RAM_DEPTH    = 1 << ADDR_WIDTH,
   parameter  int READ_LATENCY = 1,
   parameter  int FAULT_NUM    = 4,
   localparam int FBIT_W       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cs,
   input  logic                  we,
   input  logic                  re,
   input  logic                  oe,
   input  logic                  odd_bwe,
   input  logic                  even_bwe,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] d,
   output logic [DATA_WIDTH-1:0] q,
   output logic                  q_valid,
   input  logic                  fault_load,
   input  logic                  fault_clr,
   input  logic [ADDR_WIDTH-1:0] fault_addr,
   input  logic [FBIT_W-1:0]     fault_bit,
   input  logic                  fault_val
);

   localparam int IDX_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

   logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];
   logic [DATA_WIDTH-1:0] wmask;
   logic [IDX_W-1:0]      idx;
   logic                  addr_ok;
   logic                  wr_en;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] raw_word;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  pipe_valid;
   logic [DATA_WIDTH-1:0] pipe_data;

   // Decode access: reset suppresses both write and read in the same cycle
   always_comb begin
      addr_ok  = (32'(addr) < 32'(RAM_DEPTH));
      idx      = IDX_W'(addr);
      wr_en    = !rst && cs && we && addr_ok;
      rd_en    = !rst && cs && re && !we;
      raw_word = addr_ok ? mem_q[idx] : '0;
      for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
         wmask[i] = ((i % 2) == 0) ? even_bwe : odd_bwe;
      end
   end

   // Array write with per-bit odd/even masking; contents are never reset
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[idx] <= (mem_q[idx] & ~wmask) | (d & wmask);
      end
   end

`ifdef MUT_FAULT_INJECT_EN
   localparam int PTR_W = (FAULT_NUM > 1) ? $clog2(FAULT_NUM) : 1;

   mut_fault_t       slot_q [FAULT_NUM];
   mut_fault_t       slot_d [FAULT_NUM];
   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] ptr_d;

   // Slot file next state: clear beats load; load overwrites the oldest slot
   always_comb begin
      ptr_d = ptr_q;
      for (int unsigned s = 0; s < FAULT_NUM; s++) begin
         slot_d[s] = slot_q[s];
      end
      if (fault_clr) begin
         ptr_d = '0;
         for (int unsigned s = 0; s < FAULT_NUM; s++) begin
            slot_d[s].en = 1'b0;
         end
      end else if (fault_load) begin
         slot_d[ptr_q].en     = 1'b1;
         slot_d[ptr_q].addr   = MUT_FAULT_ADDR_W'(fault_addr);
         slot_d[ptr_q].bitpos = MUT_FAULT_BIT_W'(fault_bit);
         slot_d[ptr_q].val    = fault_val;
         ptr_d = (ptr_q == PTR_W'(FAULT_NUM - 1)) ? '0 : ptr_q + PTR_W'(1);
      end
   end

   // Slot file and pointer registers
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
         for (int unsigned s = 0; s < FAULT_NUM; s++) begin
            slot_q[s] <= '0;
         end
      end else begin
         ptr_q <= ptr_d;
         for (int unsigned s = 0; s < FAULT_NUM; s++) begin
            slot_q[s] <= slot_d[s];
         end
      end
   end

   // Force faulty bits on data entering the pipeline; later slots override earlier
   always_comb begin
      rd_word = raw_word;
      for (int unsigned s = 0; s < FAULT_NUM; s++) begin
         for (int unsigned b = 0; b < DATA_WIDTH; b++) begin
            if (slot_q[s].en &&
                (slot_q[s].addr == MUT_FAULT_ADDR_W'(addr)) &&
                (slot_q[s].bitpos == MUT_FAULT_BIT_W'(b))) begin
               rd_word[b] = slot_q[s].val;
            end
         end
      end
   end
`else
   logic unused_fault;
   assign unused_fault = ^{fault_load, fault_clr, fault_addr, fault_bit, fault_val};

   // Without fault injection the pipeline sees the raw array word
   always_comb begin
      rd_word = raw_word;
   end
`endif

   mut_rd_pipe #(
      .DATA_WIDTH   (DATA_WIDTH),
      .READ_LATENCY (READ_LATENCY)
   ) u_rd_pipe (
      .clk_i   (clk),
      .rst_i   (rst),
      .valid_i (rd_en),
      .data_i  (rd_word),
      .valid_o (pipe_valid),
      .data_o  (pipe_data)
   );

   assign q       = oe ? pipe_data : '0;
   assign q_valid = pipe_valid;

endmodule

// File: tb/tb_mut_ram_bwe.sv
// Directed bench for mut_ram_bwe: four instances with READ_LATENCY 1..4 share
// stimulus; the latency-2 instance implements only 12 words.
module tb_mut_ram_bwe;

   localparam int DW = 7;
   localparam int AW = 4;
`ifdef MUT_FAULT_INJECT_EN
   localparam bit FI = 1'b1;
`else
   localparam bit FI = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst, cs, we, re, oe, odd_bwe, even_bwe;
   logic [AW-1:0] addr;
   logic [DW-1:0] d;
   logic          fault_load, fault_clr, fault_val;
   logic [AW-1:0] fault_addr;
   logic [2:0]    fault_bit;

   logic [4:1][DW-1:0] q_l;
   logic [4:1]         qv_l;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   for (genvar g = 1; g <= 4; g++) begin : g_dut
      mut_ram_bwe #(
         .DATA_WIDTH   (DW),
         .ADDR_WIDTH   (AW),
         .RAM_DEPTH    ((g == 2) ? 12 : 16),
         .READ_LATENCY (g),
         .FAULT_NUM    (4)
      ) u_dut (
         .clk        (clk),
         .rst        (rst),
         .cs         (cs),
         .we         (we),
         .re         (re),
         .oe         (oe),
         .odd_bwe    (odd_bwe),
         .even_bwe   (even_bwe),
         .addr       (addr),
         .d          (d),
         .q          (q_l[g]),
         .q_valid    (qv_l[g]),
         .fault_load (fault_load),
         .fault_clr  (fault_clr),
         .fault_addr (fault_addr),
         .fault_bit  (fault_bit),
         .fault_val  (fault_val)
      );
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      rst = 0; cs = 0; we = 0; re = 0; even_bwe = 0; odd_bwe = 0;
      fault_load = 0; fault_clr = 0;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] v,
                           input logic ev, input logic od);
      cs = 1; we = 1; re = 0; addr = a; d = v; even_bwe = ev; odd_bwe = od;
      tick();
      idle();
   endtask

   task automatic do_read(input logic [AW-1:0] a);
      cs = 1; we = 0; re = 1; addr = a;
      tick();
      idle();
   endtask

   task automatic do_fault(input logic [AW-1:0] a, input logic [2:0] b, input logic v);
      fault_load = 1; fault_addr = a; fault_bit = b; fault_val = v;
      tick();
      idle();
   endtask

   task automatic test_reset();
      rst = 1;
      tick();
      tick();
      rst = 0;
      for (int L = 1; L <= 4; L++) begin
         n_tests++;
         if (qv_l[L] !== 1'b0 || q_l[L] !== 7'h00) begin
            n_fail++;
            $display("FAIL reset L=%0d: q=%h q_valid=%b expected q=00 q_valid=0", L, q_l[L], qv_l[L]);
         end
      end
   endtask

   task automatic test_bwe_mask();
      do_write(4'd3, 7'h7F, 1'b1, 1'b1);
      do_write(4'd3, 7'h00, 1'b1, 1'b0);
      do_read(4'd3);
      for (int c = 0; c < 5; c++) begin
         for (int L = 1; L <= 4; L++) begin
            n_tests++;
            if (qv_l[L] !== (c == L - 1)) begin
               n_fail++;
               $display("FAIL bwe_valid L=%0d c=%0d: q_valid=%b expected %b", L, c, qv_l[L], (c == L - 1));
            end
            if (c == L - 1) begin
               n_tests++;
               if (q_l[L] !== 7'h2A) begin
                  n_fail++;
                  $display("FAIL bwe_data L=%0d: q=%h expected 2a", L, q_l[L]);
               end
            end
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      int            r;
      logic          ev;
      logic [DW-1:0] eq;
      for (int a = 0; a < 16; a++) do_write(AW'(a), DW'(a), 1'b1, 1'b1);
      for (int c = 0; c < 20; c++) begin
         if (c < 16) begin
            cs = 1; we = 0; re = 1; addr = AW'(c);
         end else begin
            idle();
         end
         tick();
         for (int L = 1; L <= 4; L++) begin
            r  = c - L + 1;
            ev = (r >= 0) && (r < 16);
            eq = (L == 2 && r >= 12) ? 7'h00 : DW'(r);
            n_tests++;
            if (qv_l[L] !== ev) begin
               n_fail++;
               $display("FAIL b2b_valid L=%0d c=%0d: q_valid=%b expected %b", L, c, qv_l[L], ev);
            end
            if (ev) begin
               n_tests++;
               if (q_l[L] !== eq) begin
                  n_fail++;
                  $display("FAIL b2b_data L=%0d read=%0d: q=%h expected %h", L, r, q_l[L], eq);
               end
            end
         end
      end
      idle();
   endtask

   task automatic test_control_corners();
      // write with re also high: data written, no read issued
      cs = 1; we = 1; re = 1; addr = 4'd5; d = 7'h55; even_bwe = 1; odd_bwe = 1;
      tick();
      idle();
      for (int c = 0; c < 4; c++) begin
         for (int L = 1; L <= 4; L++) begin
            n_tests++;
            if (qv_l[L] !== 1'b0) begin
               n_fail++;
               $display("FAIL we_re_noread L=%0d c=%0d: q_valid=%b expected 0", L, c, qv_l[L]);
            end
         end
         tick();
      end
      do_read(4'd5);
      n_tests++;
      if (q_l[1] !== 7'h55 || qv_l[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL we_re_written: q=%h q_valid=%b expected 55/1", q_l[1], qv_l[1]);
      end
      tick();
      // oe low: q gated to zero while q_valid still pulses
      oe = 0;
      do_read(4'd5);
      n_tests++;
      if (q_l[1] !== 7'h00 || qv_l[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL oe_low L=1: q=%h q_valid=%b expected 00/1", q_l[1], qv_l[1]);
      end
      tick();
      n_tests++;
      if (q_l[2] !== 7'h00 || qv_l[2] !== 1'b1 || qv_l[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL oe_low L=2: q=%h q_valid=%b l1_valid=%b expected 00/1/0", q_l[2], qv_l[2], qv_l[1]);
      end
      oe = 1;
      #1;
      n_tests++;
      if (q_l[1] !== 7'h55) begin
         n_fail++;
         $display("FAIL hold_last: q=%h expected 55", q_l[1]);
      end
      tick();
      tick();
      tick();
   endtask

   task automatic test_reset_mid_read();
      cs = 1; we = 0; re = 1; addr = 4'd5;
      tick();
      addr = 4'd3;
      tick();
      idle();
      // reset while both reads are in flight, with a write attempt to addr 5
      rst = 1; cs = 1; we = 1; addr = 4'd5; d = 7'h00; even_bwe = 1; odd_bwe = 1;
      tick();
      idle();
      for (int c = 0; c < 4; c++) begin
         for (int L = 3; L <= 4; L++) begin
            n_tests++;
            if (qv_l[L] !== 1'b0 || q_l[L] !== 7'h00) begin
               n_fail++;
               $display("FAIL rst_inflight L=%0d c=%0d: q=%h q_valid=%b expected 00/0", L, c, q_l[L], qv_l[L]);
            end
         end
         tick();
      end
      do_read(4'd5);
      n_tests++;
      if (q_l[1] !== 7'h55) begin
         n_fail++;
         $display("FAIL rst_blocks_write: q=%h expected 55", q_l[1]);
      end
   endtask

   task automatic test_fault();
      logic [DW-1:0] e;
      do_fault(4'd2, 3'd0, 1'b1);
      do_write(4'd2, 7'h00, 1'b1, 1'b1);
      do_read(4'd2);
      e = FI ? 7'h01 : 7'h00;
      n_tests++;
      if (q_l[1] !== e) begin
         n_fail++;
         $display("FAIL fault_basic: q=%h expected %h", q_l[1], e);
      end
      fault_clr = 1;
      tick();
      idle();
      do_read(4'd2);
      n_tests++;
      if (q_l[1] !== 7'h00) begin
         n_fail++;
         $display("FAIL fault_clr: q=%h expected 00", q_l[1]);
      end
      // fault loaded at the same edge as a read does not affect that read
      fault_load = 1; fault_addr = 4'd2; fault_bit = 3'd0; fault_val = 1'b1;
      cs = 1; we = 0; re = 1; addr = 4'd2;
      tick();
      idle();
      n_tests++;
      if (q_l[1] !== 7'h00) begin
         n_fail++;
         $display("FAIL fault_same_edge: q=%h expected 00", q_l[1]);
      end
      do_read(4'd2);
      n_tests++;
      if (q_l[1] !== e) begin
         n_fail++;
         $display("FAIL fault_next_edge: q=%h expected %h", q_l[1], e);
      end
      // five loads into four slots: the first is overwritten
      fault_clr = 1;
      tick();
      idle();
      do_fault(4'd2, 3'd0, 1'b1);
      do_fault(4'd7, 3'd1, 1'b1);
      do_fault(4'd7, 3'd2, 1'b1);
      do_fault(4'd7, 3'd3, 1'b1);
      do_fault(4'd9, 3'd0, 1'b1);
      do_write(4'd7, 7'h00, 1'b1, 1'b1);
      do_write(4'd9, 7'h00, 1'b1, 1'b1);
      do_read(4'd2);
      n_tests++;
      if (q_l[1] !== 7'h00) begin
         n_fail++;
         $display("FAIL fault_wrap_oldest: q=%h expected 00", q_l[1]);
      end
      do_read(4'd9);
      e = FI ? 7'h01 : 7'h00;
      n_tests++;
      if (q_l[1] !== e) begin
         n_fail++;
         $display("FAIL fault_wrap_new: q=%h expected %h", q_l[1], e);
      end
      do_read(4'd7);
      e = FI ? 7'h0E : 7'h00;
      n_tests++;
      if (q_l[1] !== e) begin
         n_fail++;
         $display("FAIL fault_multi: q=%h expected %h", q_l[1], e);
      end
      // same addr/bit in two slots: higher slot index wins
      fault_clr = 1;
      tick();
      idle();
      do_fault(4'd4, 3'd1, 1'b1);
      do_fault(4'd4, 3'd1, 1'b0);
      do_write(4'd4, 7'h7F, 1'b1, 1'b1);
      do_read(4'd4);
      e = FI ? 7'h7D : 7'h7F;
      n_tests++;
      if (q_l[1] !== e) begin
         n_fail++;
         $display("FAIL fault_priority: q=%h expected %h", q_l[1], e);
      end
      // clear beats a simultaneous load
      fault_clr = 1; fault_load = 1; fault_addr = 4'd4; fault_bit = 3'd1; fault_val = 1'b0;
      tick();
      idle();
      do_read(4'd4);
      n_tests++;
      if (q_l[1] !== 7'h7F) begin
         n_fail++;
         $display("FAIL fault_clr_prio: q=%h expected 7f", q_l[1]);
      end
      // bit index beyond the word has no effect
      do_fault(4'd4, 3'd7, 1'b0);
      do_read(4'd4);
      n_tests++;
      if (q_l[1] !== 7'h7F) begin
         n_fail++;
         $display("FAIL fault_bit_oob: q=%h expected 7f", q_l[1]);
      end
   endtask

   initial begin
      idle();
      oe = 1; addr = '0; d = '0; fault_addr = '0; fault_bit = '0; fault_val = 0;
      @(negedge clk);
      test_reset();
      test_bwe_mask();
      test_back_to_back();
      test_control_corners();
      test_reset_mid_read();
      test_fault();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
